regfile_wb_buffered: RTL and testbench
======================================

// Module: regfile_wb_buffered
// PURPOSE
//  MIPS register file (2 read ports, 1 write port) that consumes the write-back
//  address produced by the RegDst write-register mux, plus write-back data.
//  Writes enter a small in-order write buffer through a valid/ready handshake.
//  The buffer drains one entry per cycle into the array. Reads bypass from the
//  buffer, so a value is visible the cycle after it is accepted. Sits between
//  the write-back mux path and the decode-stage operand reads.
// PARAMETERS
//  DATA_W     32  register width in bits
//  ADDR_W     5   register address width (2**ADDR_W registers)
//  BUF_DEPTH  2   write-buffer entries; power of 2, >= 2
// PORTS
//  clk            in   1          rising-edge clock
//  rst            in   1          synchronous, active-high reset
//  wr_valid       in   1          write request present
//  wr_ready       out  1          buffer can accept (= !full)
//  wr_addr        in   ADDR_W     destination register (WriteReg from RegDst mux)
//  wr_data        in   DATA_W     write-back data
//  wb_hold        in   1          1 = suppress draining this cycle
//  rd_addr_a      in   ADDR_W     read port A address (rs)
//  rd_data_a      out  DATA_W     read port A data
//  rd_addr_b      in   ADDR_W     read port B address (rt)
//  rd_data_b      out  DATA_W     read port B data
//  buf_count      out  clog2(BUF_DEPTH)+1  occupied buffer entries
// BEHAVIOUR
//  Reset (clk edge with rst=1):
//   - all registers <= 0; buffer emptied; buf_count = 0; wr_ready = 1.
//   - Pending buffered writes are discarded.
//   - rst has priority over accept and drain in the same cycle.
//  Accept:
//   - Handshake fires when wr_valid && wr_ready at the clk edge.
//   - wr_addr == 0: write is accepted (ready honoured) but NOT enqueued; $zero is never written.
//   - wr_ready depends only on buffer occupancy, never on wr_valid.
//  Drain:
//   - At each edge with buffer non-empty and wb_hold = 0:
//     mem[head.addr] <= head.data and the head entry is popped.
//   - Entries drain strictly in FIFO order.
//  Simultaneous events:
//   - Push and drain in the same cycle: buf_count is unchanged.
//   - Full buffer: wr_ready = 0, even if a drain will occur that cycle (no push-through-full).
//   - Head pointer and tail pointer wrap modulo BUF_DEPTH.
//  Reads (combinational, 0-cycle latency), per port:
//   - rd_addr == 0: output 0.
//   - Else, if one or more valid buffer entries match: data of the YOUNGEST matching entry.
//   - Else: mem[rd_addr].
//   - The write being accepted in the current cycle is NOT bypassed.
//     It becomes visible on the next cycle via the buffer.
//  Sequence guarantee: after acceptance, the value is returned by reads from the
//  next cycle on, regardless of wb_hold or drain timing.
//  Array: mem[0] reads as 0 at all times. Width rules: no truncation; all data DATA_W bits.
// TESTING
//  1. Reset: pulse rst with buffer holding 2 entries -> next cycle buf_count=0, wr_ready=1,
//     reads of r5/r31 = 0.
//  2. Write r8=0xDEADBEEF (accept cycle N) -> rd_data_a(r8) = old value in N,
//     0xDEADBEEF from N+1 onward.
//  3. Write r0=0x12345678 -> wr_ready=1, buf_count stays 0, rd_data_b(r0)=0 forever.
//  4. wb_hold=1, write r3=0x1 then r3=0x2 -> buf_count=2, wr_ready=0,
//     rd_data_a(r3)=0x2 (youngest wins).
//     Release hold -> r3 reads 0x2 throughout drain; buf_count 2->1->0.
//  5. Back-to-back writes r1..r4 with wb_hold=0 -> buf_count never exceeds 1;
//     all four read back correctly on both ports.
//  6. Full buffer plus wr_valid=1 -> no accept (data not written); a drain on the same edge
//     frees one slot, so wr_ready=1 next cycle.

Source files
------------

// File: rtl/regfile_wb_buffered.sv
// ============================================================================
// regfile_wb_buffered
// ----------------------------------------------------------------------------
// MIPS-style register file with two combinational read ports and a single
// write port. Write-back traffic (WriteReg from the RegDst mux plus data)
// enters a small in-order write buffer through a valid/ready handshake. The
// buffer retires one entry per cycle into the register array unless wb_hold
// is asserted. Reads look in the buffer first, so a value accepted in cycle N
// is returned from cycle N+1 on, whether or not it has reached the array yet.
//
// Parameters
//   DATA_W     register width in bits
//   ADDR_W     register address width (2**ADDR_W registers)
//   BUF_DEPTH  write-buffer entries (power of 2, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears array and buffer)
//   wr_valid   write request present
//   wr_ready   buffer can accept a write (buffer not full)
//   wr_addr    destination register
//   wr_data    write-back data
//   wb_hold    1 = do not drain the buffer this cycle
//   rd_addr_a  read port A address (rs)
//   rd_data_a  read port A data
//   rd_addr_b  read port B address (rt)
//   rd_data_b  read port B data
//   buf_count  number of occupied buffer entries
// ============================================================================
module regfile_wb_buffered #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         wb_hold,
    input  logic [ADDR_W-1:0]            rd_addr_a,
    output logic [DATA_W-1:0]            rd_data_a,
    input  logic [ADDR_W-1:0]            rd_addr_b,
    output logic [DATA_W-1:0]            rd_data_b,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int NUM_RD   = 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q      [NUM_REGS];
    logic [ADDR_W-1:0] buf_addr_q [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // ------------------------------------------------------------------
    // Handshake / drain decode
    // ------------------------------------------------------------------
    logic full;
    logic accept;
    logic push;
    logic drain;

    // Readiness is purely a function of occupancy. A full buffer refuses a
    // write even when the head is about to drain on the same edge, which
    // keeps wr_ready free of any path from wb_hold or wr_valid.
    always_comb begin
        full     = (count_q == CNT_W'(BUF_DEPTH));
        wr_ready = !full;
        accept   = wr_valid && !full;
        // Writes to $zero complete the handshake but never occupy a slot.
        push     = accept && (wr_addr != '0);
        drain    = (count_q != '0) && !wb_hold;
    end

    // ------------------------------------------------------------------
    // Pointer and occupancy next-state
    // ------------------------------------------------------------------
    // Pointers are PTR_W bits wide, so incrementing past BUF_DEPTH-1 wraps
    // naturally because BUF_DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end

        unique case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers (reset has priority over push and drain)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Buffer storage
    // ------------------------------------------------------------------
    // Entry contents need no reset: an entry is only ever read when it is
    // inside the [head, head+count) window, and reset empties that window.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_addr_q[tail_q] <= wr_addr;
            buf_data_q[tail_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    // The head entry retires into the array on every non-held edge. Entry
    // addresses are never zero, so mem_q[0] stays at its reset value; the
    // read path forces address 0 to zero anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (drain) begin
            mem_q[buf_addr_q[head_q]] <= buf_data_q[head_q];
        end
    end

    // ------------------------------------------------------------------
    // Read ports with buffer bypass
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr [NUM_RD];
    logic [DATA_W-1:0] rd_data [NUM_RD];
    logic [PTR_W-1:0]  scan_idx;

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;
    assign rd_data_a  = rd_data[0];
    assign rd_data_b  = rd_data[1];

    // The buffer is walked oldest to youngest starting at head, and every
    // live match overwrites the previous choice, so the youngest matching
    // entry wins. The write being accepted this cycle is not yet in the
    // buffer and is therefore deliberately not visible until next cycle.
    always_comb begin
        scan_idx = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            for (int k = 0; k < BUF_DEPTH; k++) begin
                scan_idx = head_q + PTR_W'(k);
                if ((CNT_W'(k) < count_q) && (buf_addr_q[scan_idx] == rd_addr[p])) begin
                    rd_data[p] = buf_data_q[scan_idx];
                end
            end
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

    assign buf_count = count_q;

endmodule

// File: tb/tb_regfile_wb_buffered.sv
// ============================================================================
// tb_regfile_wb_buffered
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_wb_buffered. A behavioural model (register
// array plus a queue of pending writes) predicts ready, occupancy and both
// read ports every cycle. Directed scenarios are followed by random traffic.
// ============================================================================
module tb_regfile_wb_buffered;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wb_hold;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic [CNT_W-1:0]  buf_count;

    regfile_wb_buffered #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wb_hold   (wb_hold),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .buf_count (buf_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: architectural registers plus pending-write queue
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } entry_t;

    logic [DATA_W-1:0] refMem [2**ADDR_W];
    entry_t            refQ   [$];

    int checkCount = 0;
    int passCount  = 0;

    function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] a);
        if (a == '0) return '0;
        for (int i = refQ.size() - 1; i >= 0; i--) begin
            if (refQ[i].a == a) return refQ[i].d;
        end
        return refMem[a];
    endfunction

    // The newest pending write to an address wins; when there is none the
    // architectural value is returned. Retirement moves the oldest pending
    // write into the architectural state.
    task automatic modelEdge(input logic v, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic h);
        bit     acc;
        bit     dr;
        entry_t e;
        acc = v && (refQ.size() < BUF_DEPTH);
        dr  = (refQ.size() > 0) && !h;
        if (dr) begin
            e = refQ.pop_front();
            refMem[e.a] = e.d;
        end
        if (acc && (a != '0)) begin
            e.a = a;
            e.d = d;
            refQ.push_back(e);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2**ADDR_W; i++) refMem[i] = '0;
        refQ.delete();
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic checkModel(input string where);
        checkOutput({where, ".wr_ready"}, DATA_W'(wr_ready),
                    DATA_W'(refQ.size() < BUF_DEPTH));
        checkOutput({where, ".buf_count"}, DATA_W'(buf_count), DATA_W'(refQ.size()));
        checkOutput({where, ".rd_data_a"}, rd_data_a, expRead(rd_addr_a));
        checkOutput({where, ".rd_data_b"}, rd_data_b, expRead(rd_addr_b));
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance model at edge.
    task automatic applyStimulus(input string where, input logic v,
                                 input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                 input logic h, input logic [ADDR_W-1:0] ra,
                                 input logic [ADDR_W-1:0] rb);
        rst       = 1'b0;
        wr_valid  = v;
        wr_addr   = a;
        wr_data   = d;
        wb_hold   = h;
        rd_addr_a = ra;
        rd_addr_b = rb;
        @(negedge clk);
        checkModel(where);
        @(posedge clk);
        modelEdge(v, a, d, h);
        #1;
    endtask

    task automatic resetPulse();
        rst      = 1'b1;
        wr_valid = 1'b0;
        wb_hold  = 1'b0;
        @(posedge clk);
        modelReset();
        #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        wb_hold   = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        modelReset();

        // Reset with two pending entries discards them
        resetPulse();
        applyStimulus("t1.fill0", 1'b1, 5'd5,  32'hAAAA_0005, 1'b1, 5'd5, 5'd31);
        applyStimulus("t1.fill1", 1'b1, 5'd31, 32'hBBBB_001F, 1'b1, 5'd5, 5'd31);
        checkOutput("t1.full_count", DATA_W'(buf_count), 32'd2);
        resetPulse();
        #1;
        checkOutput("t1.rst_count", DATA_W'(buf_count), 32'd0);
        checkOutput("t1.rst_ready", DATA_W'(wr_ready), 32'd1);
        checkOutput("t1.rst_r5",    rd_data_a, 32'd0);
        checkOutput("t1.rst_r31",   rd_data_b, 32'd0);

        // Write visible the cycle after acceptance
        applyStimulus("t2.accept", 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd8, 5'd8);
        checkOutput("t2.next_cycle", rd_data_a, 32'hDEAD_BEEF);
        applyStimulus("t2.after", 1'b0, 5'd0, 32'h0, 1'b0, 5'd8, 5'd9);
        checkOutput("t2.in_array", rd_data_a, 32'hDEAD_BEEF);

        // $zero write is accepted but never stored
        applyStimulus("t3.accept", 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd8, 5'd0);
        checkOutput("t3.count", DATA_W'(buf_count), 32'd0);
        checkOutput("t3.r0",    rd_data_b, 32'd0);
        applyStimulus("t3.after", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

        // Held buffer, youngest matching entry wins
        applyStimulus("t4.w1", 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 5'd3);
        applyStimulus("t4.w2", 1'b1, 5'd3, 32'h2, 1'b1, 5'd3, 5'd3);
        checkOutput("t4.count2", DATA_W'(buf_count), 32'd2);
        checkOutput("t4.ready0", DATA_W'(wr_ready), 32'd0);
        checkOutput("t4.youngest", rd_data_a, 32'h2);
        applyStimulus("t4.hold", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
        applyStimulus("t4.drain1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
        checkOutput("t4.count1", DATA_W'(buf_count), 32'd1);
        checkOutput("t4.r3_mid", rd_data_a, 32'h2);
        applyStimulus("t4.drain2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
        checkOutput("t4.count0", DATA_W'(buf_count), 32'd0);
        checkOutput("t4.r3_end", rd_data_a, 32'h2);

        // Back-to-back writes with draining keep occupancy at most 1
        for (int i = 1; i <= 4; i++) begin
            applyStimulus("t5.write", 1'b1, ADDR_W'(i), 32'hC0DE_0000 + 32'(i), 1'b0,
                          ADDR_W'(i), ADDR_W'(i));
            checkOutput("t5.count_le1", DATA_W'(buf_count <= 1), 32'd1);
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus("t5.read", 1'b0, 5'd0, 32'h0, 1'b0, ADDR_W'(i), ADDR_W'(5 - i));
        end

        // Full buffer refuses a write even while the head drains
        applyStimulus("t6.f0", 1'b1, 5'd6, 32'h6666_0006, 1'b1, 5'd6, 5'd7);
        applyStimulus("t6.f1", 1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd6, 5'd7);
        applyStimulus("t6.refuse", 1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd9, 5'd7);
        checkOutput("t6.ready_next", DATA_W'(wr_ready), 32'd1);
        checkOutput("t6.count_next", DATA_W'(buf_count), 32'd1);
        applyStimulus("t6.r9", 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd6);
        checkOutput("t6.r9_unwritten", rd_data_a, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a, ra, rb;
            a  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
            if (n == 200) resetPulse();
            applyStimulus("rand", 1'($urandom_range(0, 1)), a, $urandom,
                          ($urandom_range(0, 9) < 3), ra, rb);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
